// File: rtl/microsequencer_if.sv
// Control-sequencer bus: instruction/memory/condition inputs toward the sequencer
// and its state/status outputs toward the control unit.
interface microsequencer_if;
    logic [31:0] ir;
    logic        moc;
    logic        cond_true;
    logic [6:0]  state;
    logic        instr_done;
    logic        undef_instr;
    logic        bus_err;

    modport master (
        output ir, moc, cond_true,
        input  state, instr_done, undef_instr, bus_err
    );

    modport slave (
        input  ir, moc, cond_true,
        output state, instr_done, undef_instr, bus_err
    );
endinterface

// File: rtl/microsequencer.sv
// Control-state sequencer: fetch/decode/DP/branch/load/store flows as a Moore machine.
// Optional memory-wait timeout with sticky bus_err is built when SEQ_TIMEOUT_EN is defined.
module microsequencer #(
    parameter int TIMEOUT_CYCLES = 16,
    parameter int CNT_W          = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    microsequencer_if.slave  bus
);

    typedef enum logic [6:0] {
        S_RESET      = 7'd0,
        S_FETCH1     = 7'd1,
        S_FETCH2     = 7'd2,
        S_FETCH_WAIT = 7'd3,
        S_DECODE     = 7'd4,
        S_DP_REG     = 7'd5,
        S_DP_IMM     = 7'd6,
        S_B          = 7'd7,
        S_BL         = 7'd8,
        S_LD_IMM     = 7'd33,
        S_LD_WAIT    = 7'd34,
        S_LD_DATA    = 7'd35,
        S_LD_WR      = 7'd36,
        S_LD_WB      = 7'd38,
        S_ST_WB      = 7'd39,
        S_ST_IMM     = 7'd40,
        S_ST_ADDR    = 7'd41,
        S_ST_WAIT    = 7'd42,
        S_ST_REG     = 7'd46,
        S_LD_REG     = 7'd47
    } state_e;

    state_e state_q, state_d;
    logic   instr_done_q, instr_done_d;
    logic   undef_instr_q, undef_instr_d;
    logic   timeout_s;
    logic   writeback_s;

    function automatic logic is_wait(input state_e s);
        return (s == S_FETCH_WAIT) || (s == S_LD_WAIT) || (s == S_ST_WAIT);
    endfunction

    // Base-register writeback: post-indexed, or pre-indexed with W set.
    assign writeback_s = ~bus.ir[24] | bus.ir[21];

`ifdef SEQ_TIMEOUT_EN
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             bus_err_q, bus_err_d;

    assign timeout_s = is_wait(state_q) && !bus.moc &&
                       (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

    // Wait counter restarts on each wait-state entry, then counts moc-low cycles.
    always_comb begin
        bus_err_d = bus_err_q | timeout_s;
        if (is_wait(state_d) && (state_d != state_q)) begin
            cnt_d = {CNT_W{1'b0}};
        end else if (is_wait(state_q) && !bus.moc) begin
            cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Timeout counter and sticky error flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q     <= {CNT_W{1'b0}};
            bus_err_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            bus_err_q <= bus_err_d;
        end
    end

    assign bus.bus_err = bus_err_q;
`else
    assign timeout_s   = 1'b0;
    assign bus.bus_err = 1'b0;
`endif

    // Next-state and next-flag decode.
    always_comb begin
        state_d       = state_q;
        instr_done_d  = 1'b0;
        undef_instr_d = 1'b0;
        case (state_q)
            S_RESET:  state_d = S_FETCH1;
            S_FETCH1: state_d = S_FETCH2;
            S_FETCH2: state_d = S_FETCH_WAIT;
            S_FETCH_WAIT: begin
                if (bus.moc)        state_d = S_DECODE;
                else if (timeout_s) state_d = S_RESET;
                else                state_d = S_FETCH_WAIT;
            end
            S_DECODE: begin
                if (!bus.cond_true) begin
                    state_d      = S_FETCH1;
                    instr_done_d = 1'b1;
                end else begin
                    case (bus.ir[27:25])
                        3'b000:  state_d = S_DP_REG;
                        3'b001:  state_d = S_DP_IMM;
                        3'b101:  state_d = bus.ir[24] ? S_BL : S_B;
                        3'b010:  state_d = bus.ir[20] ? S_LD_IMM : S_ST_IMM;
                        3'b011:  state_d = bus.ir[20] ? S_LD_REG : S_ST_REG;
                        default: begin
                            state_d       = S_FETCH1;
                            undef_instr_d = 1'b1;
                        end
                    endcase
                end
            end
            S_DP_REG, S_DP_IMM, S_B, S_BL, S_LD_WB, S_ST_WB: begin
                state_d      = S_FETCH1;
                instr_done_d = 1'b1;
            end
            S_LD_IMM, S_LD_REG: state_d = S_LD_WAIT;
            S_LD_WAIT: begin
                if (bus.moc)        state_d = S_LD_DATA;
                else if (timeout_s) state_d = S_RESET;
                else                state_d = S_LD_WAIT;
            end
            S_LD_DATA: state_d = S_LD_WR;
            S_LD_WR: begin
                if (writeback_s) begin
                    state_d = S_LD_WB;
                end else begin
                    state_d      = S_FETCH1;
                    instr_done_d = 1'b1;
                end
            end
            S_ST_IMM, S_ST_REG: state_d = S_ST_ADDR;
            S_ST_ADDR:          state_d = S_ST_WAIT;
            S_ST_WAIT: begin
                if (bus.moc && writeback_s) begin
                    state_d = S_ST_WB;
                end else if (bus.moc) begin
                    state_d      = S_FETCH1;
                    instr_done_d = 1'b1;
                end else if (timeout_s) begin
                    state_d = S_RESET;
                end else begin
                    state_d = S_ST_WAIT;
                end
            end
            default: state_d = S_RESET;
        endcase
    end

    // State register and registered pulse outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_RESET;
            instr_done_q  <= 1'b0;
            undef_instr_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            instr_done_q  <= instr_done_d;
            undef_instr_q <= undef_instr_d;
        end
    end

    assign bus.state       = state_q;
    assign bus.instr_done  = instr_done_q;
    assign bus.undef_instr = undef_instr_q;

endmodule
